// File: rtl/pkt_tx_arbiter.sv
// pkt_tx_arbiter
//   Shares one outbound packet link between NUM_SRC free-running packet
//   sources. Each source has a private flit FIFO. A round-robin wormhole
//   arbiter grants the link at a HEAD flit and holds the grant until the
//   matching TAIL, so packets are never interleaved on out_flit.
//
// Ports
//   clk        in   1                  clock
//   rst        in   1                  asynchronous, active-high reset
//   in_flit    in   NUM_SRC*FW         source flits, source i at [i*FW +: FW]
//   out_ready  in   1                  downstream accepts a flit this cycle
//   out_flit   out  FW                 registered output flit, 0 = idle
//   busy       out  1                  locked, or any FIFO non-empty
//   overflow   out  NUM_SRC            sticky: flit from source i dropped (FIFO full)
//   proto_err  out  NUM_SRC            sticky: framing violation seen on source i
//
// Flit layout: {flow[`FLOWBH:`FLOWBL], payload[`FLOWBL-1:0]}, FW = `PKTW+1.
// A flow code of 0 marks an idle cycle and is never stored.
//
// FSM states
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no owner; search for a HEAD, discard stray BODY/TAIL heads
//   S_LOCKED | owner holds the link until its TAIL is forwarded

`ifndef PKTW
`define PKTW 17
`endif
`ifndef FLOWBH
`define FLOWBH 17
`endif
`ifndef FLOWBL
`define FLOWBL 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module pkt_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*(`PKTW+1)-1:0]  in_flit,
    input  logic                          out_ready,
    output logic [`PKTW:0]                out_flit,
    output logic                          busy,
    output logic [NUM_SRC-1:0]            overflow,
    output logic [NUM_SRC-1:0]            proto_err
);

    localparam int FW  = `PKTW + 1;
    localparam int FLW = `FLOWBH - `FLOWBL + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0]                 owner, owner_nxt;
    logic [SW-1:0]                 rr_ptr, rr_nxt;
    logic [FW-1:0]                 out_nxt;

    logic [NUM_SRC-1:0][FW-1:0]    head_flit;
    logic [NUM_SRC-1:0][FLW-1:0]   head_flow;
    logic [NUM_SRC-1:0]            empty;
    logic [NUM_SRC-1:0]            push;
    logic [NUM_SRC-1:0]            drop;
    logic [NUM_SRC-1:0]            pop;
    logic [NUM_SRC-1:0]            perr_set;

    logic                          grant_found;
    logic [SW-1:0]                 grant_src;
    logic [SW:0]                   cand;

    logic [FLW-1:0]                owner_flow;
    logic                          fwd_owner;

    // ------------------------------------------------------------------
    // Per-source FIFOs. Pointers carry one extra wrap bit so that
    // full (wr-rd == DEPTH) and empty (wr == rd) are distinguishable.
    // Fullness is judged before this cycle's pop, so a full FIFO drops
    // the incoming flit even if it is also being popped.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [FW-1:0] src_flit;
        logic          src_valid;
        logic          src_full;
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [FW-1:0] mem [DEPTH];

        assign src_flit  = in_flit[g*FW +: FW];
        assign src_valid = |src_flit[`FLOWBH:`FLOWBL];
        assign src_full  = ((wr_ptr - rd_ptr) == PW'(DEPTH));

        assign empty[g]     = (wr_ptr == rd_ptr);
        assign push[g]      = src_valid && !src_full;
        assign drop[g]      = src_valid && src_full;
        assign head_flit[g] = mem[rd_ptr[AW-1:0]];
        assign head_flow[g] = head_flit[g][`FLOWBH:`FLOWBL];

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr[AW-1:0]] <= src_flit;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search: rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC), first
    // non-empty FIFO whose head is a HEAD flit wins. cand is one bit
    // wider than rr_ptr so the sum cannot wrap before the modulo fixup.
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_src   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (SW+1)'(k);
            if (cand >= (SW+1)'(NUM_SRC)) begin
                cand = cand - (SW+1)'(NUM_SRC);
            end
            if (!grant_found && !empty[cand[SW-1:0]] &&
                head_flow[cand[SW-1:0]] == `HEAD) begin
                grant_found = 1'b1;
                grant_src   = cand[SW-1:0];
            end
        end
    end

    assign owner_flow = head_flow[owner];
    assign fwd_owner  = out_ready && !empty[owner];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_found && out_ready) begin
                    state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (fwd_owner && owner_flow == `TAIL) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pops, forwarded flit, owner / pointer updates)
    // In IDLE, stray BODY/TAIL heads are flushed from every FIFO in
    // parallel regardless of out_ready; the granted source always has a
    // HEAD at its head, so it never collides with a discard.
    // ------------------------------------------------------------------
    always_comb begin
        pop       = '0;
        perr_set  = '0;
        out_nxt   = '0;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        case (state)
            S_IDLE: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (!empty[i] && head_flow[i] != `HEAD) begin
                        pop[i]      = 1'b1;
                        perr_set[i] = 1'b1;
                    end
                end
                if (grant_found && out_ready) begin
                    pop[grant_src] = 1'b1;
                    out_nxt        = head_flit[grant_src];
                    owner_nxt      = grant_src;
                end
            end
            S_LOCKED: begin
                if (fwd_owner) begin
                    pop[owner] = 1'b1;
                    out_nxt    = head_flit[owner];
                    if (owner_flow == `TAIL) begin
                        rr_nxt = owner;
                    end
                    // A second HEAD inside a packet is forwarded but flagged;
                    // the lock stays with the current owner.
                    if (owner_flow == `HEAD) begin
                        perr_set[owner] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flit  <= '0;
            owner     <= '0;
            rr_ptr    <= SW'(NUM_SRC - 1);
            overflow  <= '0;
            proto_err <= '0;
        end else begin
            out_flit  <= out_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            overflow  <= overflow | drop;
            proto_err <= proto_err | perr_set;
        end
    end

    assign busy = (state == S_LOCKED) || !(&empty);

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// tb_pkt_tx_arbiter
//   Drives pkt_tx_arbiter with directed packet scenarios and randomized
//   traffic, comparing every cycle against a queue-based reference model.

`ifndef PKTW
`define PKTW 17
`endif
`ifndef FLOWBH
`define FLOWBH 17
`endif
`ifndef FLOWBL
`define FLOWBL 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_pkt_tx_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int FW = `PKTW + 1;
    localparam int FLW = `FLOWBH - `FLOWBL + 1;

    localparam logic [FLW-1:0] F_HEAD = `HEAD;
    localparam logic [FLW-1:0] F_BODY = `BODY;
    localparam logic [FLW-1:0] F_TAIL = `TAIL;

    logic              clk;
    logic              rst;
    logic [N*FW-1:0]   in_flit;
    logic              out_ready;
    logic [FW-1:0]     out_flit;
    logic              busy;
    logic [N-1:0]      overflow;
    logic [N-1:0]      proto_err;

    pkt_tx_arbiter #(.NUM_SRC(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .busy      (busy),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] mq [N][$];
    bit            m_locked;
    int            m_owner;
    int            m_rr;
    logic [N-1:0]  m_ovf;
    logic [N-1:0]  m_perr;
    logic [FW-1:0] m_out;

    function automatic logic [FW-1:0] mk(input logic [FLW-1:0] fl, input int pl);
        logic [FW-1:0] f;
        f = '0;
        f[`FLOWBH:`FLOWBL] = fl;
        f[`FLOWBL-1:0]     = pl[`FLOWBL-1:0];
        return f;
    endfunction

    function automatic logic [N*FW-1:0] put(input int s, input logic [FW-1:0] f);
        logic [N*FW-1:0] v;
        v = '0;
        v[s*FW +: FW] = f;
        return v;
    endfunction

    function automatic logic [FLW-1:0] flow_of(input logic [FW-1:0] f);
        return f[`FLOWBH:`FLOWBL];
    endfunction

    function automatic bit m_busy();
        bit b;
        b = m_locked;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = N - 1;
        m_ovf    = '0;
        m_perr   = '0;
        m_out    = '0;
    endtask

    task automatic model_step(input logic [N*FW-1:0] fin, input bit rdy);
        int            sz [N];
        bit            pop [N];
        int            g;
        int            s;
        logic [FW-1:0] hd;
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) begin
            sz[i]  = mq[i].size();
            pop[i] = 1'b0;
        end
        m_out = '0;
        if (!m_locked) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                s = (m_rr + k) % N;
                if (g < 0 && sz[s] > 0) begin
                    hd = mq[s][0];
                    if (flow_of(hd) == F_HEAD) g = s;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (sz[i] > 0) begin
                    hd = mq[i][0];
                    if (flow_of(hd) != F_HEAD) begin
                        pop[i]    = 1'b1;
                        m_perr[i] = 1'b1;
                    end
                end
            end
            if (g >= 0 && rdy) begin
                m_out    = mq[g][0];
                pop[g]   = 1'b1;
                m_owner  = g;
                m_locked = 1'b1;
            end
        end else if (rdy && sz[m_owner] > 0) begin
            hd             = mq[m_owner][0];
            m_out          = hd;
            pop[m_owner]   = 1'b1;
            if (flow_of(hd) == F_TAIL) begin
                m_rr     = m_owner;
                m_locked = 1'b0;
            end else if (flow_of(hd) == F_HEAD) begin
                m_perr[m_owner] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pop[i]) void'(mq[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            f = fin[i*FW +: FW];
            if (flow_of(f) != '0) begin
                if (sz[i] >= D) m_ovf[i] = 1'b1;
                else            mq[i].push_back(f);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [N*FW-1:0] fin, input bit rdy);
        in_flit   = fin;
        out_ready = rdy;
        @(posedge clk);
        model_step(fin, rdy);
        #1;
        check_eq("out_flit",  out_flit,  m_out);
        check_eq("busy",      busy,      m_busy());
        check_eq("overflow",  overflow,  m_ovf);
        check_eq("proto_err", proto_err, m_perr);
        if (out_flit != '0) n_out++;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_out_flit",  out_flit,  0);
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_overflow",  overflow,  0);
        check_eq("rst_proto_err", proto_err, 0);
        model_reset();
        in_flit   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    int            rem [N];
    int            rdy_pct;
    logic [N*FW-1:0] fin;
    logic [FW-1:0] f;

    initial begin
        rst       = 1'b0;
        in_flit   = '0;
        out_ready = 1'b0;
        model_reset();

        // T1: single 4-flit packet, HEAD one edge after sampling
        do_reset();
        step(put(0, mk(F_HEAD, 'h02)), 1);
        check_eq("t1_latency", out_flit, 0);
        step(put(0, mk(F_BODY, 'ha5)), 1);
        check_eq("t1_head", out_flit, mk(F_HEAD, 'h02));
        step(put(0, mk(F_BODY, 'h3c)), 1);
        check_eq("t1_body", out_flit, mk(F_BODY, 'ha5));
        step(put(0, mk(F_TAIL, 'h00)), 1);
        repeat (4) step('0, 1);

        // T2: src1 and src2 collide; then probe rr pointer with another collision
        do_reset();
        step(put(1, mk(F_HEAD, 'h11)) | put(2, mk(F_HEAD, 'h21)), 1);
        step(put(1, mk(F_BODY, 'h12)) | put(2, mk(F_BODY, 'h22)), 1);
        step(put(1, mk(F_TAIL, 'h13)) | put(2, mk(F_TAIL, 'h23)), 1);
        repeat (6) step('0, 1);
        step(put(1, mk(F_HEAD, 'h31)) | put(2, mk(F_HEAD, 'h41)), 1);
        step(put(1, mk(F_TAIL, 'h32)) | put(2, mk(F_TAIL, 'h42)), 1);
        check_eq("t2_rr_next", out_flit, mk(F_HEAD, 'h31));
        repeat (5) step('0, 1);

        // T3: src0 back-to-back while src3 waits
        do_reset();
        step(put(0, mk(F_HEAD, 'h01)) | put(3, mk(F_HEAD, 'h301)), 1);
        step(put(0, mk(F_BODY, 'h02)) | put(3, mk(F_TAIL, 'h302)), 1);
        step(put(0, mk(F_TAIL, 'h03)), 1);
        step(put(0, mk(F_HEAD, 'h04)), 1);
        step(put(0, mk(F_BODY, 'h05)), 1);
        step(put(0, mk(F_TAIL, 'h06)), 1);
        repeat (8) step('0, 1);

        // T4: out_ready toggling during a 6-flit packet
        do_reset();
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      f = mk(F_HEAD, 'h200);
            else if (i == 5) f = mk(F_TAIL, 'h205);
            else             f = mk(F_BODY, 'h200 + i);
            step(put(2, f), (i % 2) == 0);
        end
        for (int i = 0; i < 14; i++) step('0, (i % 2) == 0);
        check_eq("t4_count", n_out, 6);

        // T5: overflow while locked and stalled
        do_reset();
        step(put(0, mk(F_HEAD, 'h500)), 1);
        step('0, 1);
        for (int i = 1; i <= 10; i++) step(put(0, mk(F_BODY, 'h500 + i)), 0);
        n_out = 0;
        repeat (12) step('0, 1);
        check_eq("t5_count", n_out, 8);
        check_eq("t5_ovf", overflow[0], 1);

        // T6: stray BODY in IDLE, then reset mid-packet
        do_reset();
        step(put(1, mk(F_BODY, 'h600)), 1);
        step('0, 1);
        check_eq("t6_perr", proto_err[1], 1);
        step(put(0, mk(F_HEAD, 'h610)), 1);
        step(put(0, mk(F_BODY, 'h611)), 1);
        step(put(0, mk(F_BODY, 'h612)), 1);
        do_reset();
        step(put(0, mk(F_HEAD, 'h620)), 1);
        step(put(0, mk(F_TAIL, 'h621)), 1);
        check_eq("t6_after_rst", out_flit, mk(F_HEAD, 'h620));
        repeat (3) step('0, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        rdy_pct = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 90;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 10;
                endcase
            end
            if (c == 1500) begin
                do_reset();
                for (int i = 0; i < N; i++) rem[i] = 0;
            end
            fin = '0;
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 99) < 35) begin
                    if (rem[s] == 0) begin
                        if ($urandom_range(0, 19) == 0) begin
                            f = mk(F_BODY, int'($urandom));
                        end else begin
                            f = mk(F_HEAD, int'($urandom));
                            rem[s] = $urandom_range(1, 5);
                        end
                    end else begin
                        rem[s]--;
                        if (rem[s] == 0)                  f = mk(F_TAIL, int'($urandom));
                        else if ($urandom_range(0, 29) == 0) f = mk(F_HEAD, int'($urandom));
                        else                              f = mk(F_BODY, int'($urandom));
                    end
                    fin[s*FW +: FW] = f;
                end
            end
            step(fin, $urandom_range(0, 99) < rdy_pct);
        end
        repeat (40) step('0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
